fft_r2_sdf_stage: RTL and testbench
===================================

// Module: fft_r2_sdf_stage
// PURPOSE
// Parametrised radix-2 single-delay-feedback butterfly stage for the lane-parallel FFT pipeline.
// Each frame is 2*DEPTH accepted beats of LANES complex samples. The first half is buffered.
// The second half is butterflied against the buffered half: sums are emitted at once, differences
// are stored and emitted in the next frame's first half or by an explicit drain. Optional /2 scaling.
// PARAMETERS
// DATA_W  10  input sample width, signed two's complement, per re/im component
// LANES   16  complex samples per beat
// DEPTH   8   beats per half-frame (feedback buffer depth); >=1, power of 2 not required
// PORTS
// clk        in   1               clock
// rstn       in   1               reset, asynchronous, active-low
// sync_clr   in   1               synchronous clear: counter, pending flag, FSM -> FILL
// scale_en   in   1               1: outputs are (a+-b)/2 rounded; sampled at first beat of frame
// din_valid  in   1               input beat valid; accepted when din_valid && din_ready
// din_ready  out  1               0 only in DRAIN
// din_re     in   [LANES][DATA_W] real parts, lane 0 first
// din_im     in   [LANES][DATA_W] imag parts
// drain      in   1               request flush of stored differences (honoured only at frame boundary)
// dout_valid out  1               output beat valid (registered)
// dout_re    out  [LANES][DATA_W+1] real results
// dout_im    out  [LANES][DATA_W+1] imag results
// dout_diff  out  1               1: beat carries differences (a-b); 0: sums (a+b)
// frame_done out  1               1-cycle pulse with the last sum beat of a frame (cnt=2*DEPTH-1)
// BEHAVIOUR
// - Reset/sync_clr: all outputs 0 except din_ready=1; cnt=0; pending=0; state=FILL; buffer not cleared.
// - cnt: 0..2*DEPTH-1, advances only on accepted beats, wraps to 0. din_valid=0 holds all state (stall).
// - FSM states FILL (cnt<DEPTH), BFLY (cnt>=DEPTH), DRAIN.
// - FILL beat at slot k=cnt: if pending, dout<=buf[k] with dout_diff=1, dout_valid=1; else dout_valid=0.
//   Then buf[k] <= sign-extended din. At k=DEPTH-1 pending<=0, state->BFLY.
// - BFLY beat at k=cnt-DEPTH: a=buf[k], b=din (sign-extended to DATA_W+1).
//   dout<=S(a+b), dout_diff=0, dout_valid=1; buf[k]<=S(a-b). At k=DEPTH-1: pending<=1,
//   frame_done=1, state->FILL.
// - Arithmetic: sum/diff computed at DATA_W+2 bits. S(x)=x[DATA_W:0] if scale latched 0
//   (cannot overflow); else (x+1)>>>1 (round half up), also fits DATA_W+1.
//   Stored diffs are already scaled; they are emitted unmodified.
// - scale latch: captured on the accepted beat with cnt=0; applies to that frame's sums and diffs.
// - Latency: exactly 1 cycle from accepted beat to its output; dout_valid=0 on cycles without output.
// - DRAIN: entered from FILL when cnt=0, pending=1, drain=1. din_ready=0.
//   Emits buf[0..DEPTH-1] on DEPTH consecutive cycles (dout_diff=1). Then pending=0, state FILL, din_ready=1.
//   drain with pending=0 or cnt!=0 is ignored.
//   If drain and din_valid are both high at cnt=0 with pending=1, drain wins; din not accepted.
// - Async reset or sync_clr mid-frame/mid-drain: partial frame and pending diffs discarded.
//   First beat afterwards is treated as cnt=0 of a new frame.
// TESTING
// - Reset: rstn=0 -> dout_valid=0, dout_*=0, frame_done=0, din_ready=1; after release the first 8 beats
//   produce dout_valid=0.
// - Basic frame (scale=0): beats 0..7 re=k+1, im=0; beats 8..15 re=10.
//   Sum beats 1 cycle later re=11..18, im=0, frame_done with last.
//   Next frame's fill beats emit re=-9..-2, dout_diff=1.
// - Extremes: a=-512,b=-512 -> sum -1024; scale=1 -> -512.
//   a=511,b=-512 -> diff 1023; scale=1 -> 512. a=511,b=511 scale=1 -> 511.
// - Stall: din_valid low 3 cycles at cnt=5 -> dout_valid=0 those cycles.
//   Outputs otherwise identical to an unstalled run; scale toggled mid-frame has no effect.
// - Drain: after one frame, drain=1 -> din_ready=0 for 8 cycles with 8 diff beats in order.
//   din_valid during drain is ignored. Then din_ready=1 and a fresh frame gives no diff outputs.
// - Mid-operation clear: sync_clr at cnt=11 -> next cycle dout_valid=0, frame restarts.
//   A new full frame yields only sums; no stale diffs. Repeat with rstn pulse instead of sync_clr.

Source files
------------

// File: rtl/fft_r2_sdf_stage_if.sv
// Streaming bus for the radix-2 SDF butterfly stage: one beat of LANES complex samples in,
// one beat of butterfly results out.
interface fft_r2_sdf_stage_if #(
    parameter int DATA_W = 10,
    parameter int LANES  = 16
);
    logic                         din_valid;
    logic                         din_ready;
    logic [LANES-1:0][DATA_W-1:0] din_re;
    logic [LANES-1:0][DATA_W-1:0] din_im;
    logic                         dout_valid;
    logic [LANES-1:0][DATA_W:0]   dout_re;
    logic [LANES-1:0][DATA_W:0]   dout_im;
    logic                         dout_diff;
    logic                         frame_done;

    modport master (
        output din_valid, din_re, din_im,
        input  din_ready, dout_valid, dout_re, dout_im, dout_diff, frame_done
    );

    modport slave (
        input  din_valid, din_re, din_im,
        output din_ready, dout_valid, dout_re, dout_im, dout_diff, frame_done
    );
endinterface

// File: rtl/fft_r2_sdf_stage.sv
// Radix-2 single-delay-feedback butterfly stage: buffers the first half-frame, emits sums during
// the second half and replays the stored differences in the next first half or on a drain.
module fft_r2_sdf_stage #(
    parameter int DATA_W = 10,
    parameter int LANES  = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sync_clr,
    input  logic              scale_en,
    input  logic              drain,
    fft_r2_sdf_stage_if.slave io
);
    localparam int CW = $clog2(2 * DEPTH);
    localparam int KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic signed [DATA_W+1:0] ONE = {{(DATA_W + 1){1'b0}}, 1'b1};

    // Index 0 carries the real component, index 1 the imaginary one.
    typedef logic [1:0][LANES-1:0][DATA_W:0] cword_t;
    typedef enum logic [1:0] {FILL, BFLY, DRAIN} state_t;

    state_t                           state;
    logic   [CW-1:0]                  cnt;
    logic                             pending;
    logic                             scale_q;
    cword_t                           mem [DEPTH];
    logic   [CW-1:0]                  slot;
    logic   [KW-1:0]                  k;
    logic                             last_k;
    logic                             drain_start;
    logic                             accept;
    logic   [1:0][LANES-1:0][DATA_W-1:0] din_c;
    cword_t                           rd_w;
    cword_t                           ext_in;
    cword_t                           sum_w;
    cword_t                           diff_w;
    logic signed [DATA_W+1:0]         a;
    logic signed [DATA_W+1:0]         b;

    function automatic logic [DATA_W:0] scale_fn(input logic signed [DATA_W+1:0] x, input logic s);
        logic signed [DATA_W+1:0] r;
        r = (x + ONE) >>> 1;
        return s ? r[DATA_W:0] : x[DATA_W:0];
    endfunction

    // A drain request at a frame boundary takes priority over an incoming beat, so ready drops here.
    assign drain_start  = (state == FILL) && (cnt == '0) && pending && drain;
    assign io.din_ready = (state != DRAIN) && !drain_start;
    assign accept       = io.din_valid && io.din_ready;

    assign slot   = (state == BFLY) ? cnt - CW'(DEPTH) : cnt;
    assign k      = slot[KW-1:0];
    assign last_k = (k == KW'(DEPTH - 1));
    assign rd_w   = mem[k];
    assign din_c  = {io.din_im, io.din_re};

    always_comb begin
        ext_in = '0;
        sum_w  = '0;
        diff_w = '0;
        a      = '0;
        b      = '0;
        for (int c = 0; c < 2; c++) begin
            for (int l = 0; l < LANES; l++) begin
                ext_in[c][l] = {din_c[c][l][DATA_W-1], din_c[c][l]};
                a            = {rd_w[c][l][DATA_W], rd_w[c][l]};
                b            = {{2{din_c[c][l][DATA_W-1]}}, din_c[c][l]};
                sum_w[c][l]  = scale_fn(a + b, scale_q);
                diff_w[c][l] = scale_fn(a - b, scale_q);
            end
        end
    end

    // The feedback buffer is never reset; the pending flag decides whether its contents matter.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[k] <= (state == BFLY) ? diff_w : ext_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= FILL;
            cnt           <= '0;
            pending       <= 1'b0;
            scale_q       <= 1'b0;
            io.dout_valid <= 1'b0;
            io.dout_re    <= '0;
            io.dout_im    <= '0;
            io.dout_diff  <= 1'b0;
            io.frame_done <= 1'b0;
        end else if (sync_clr) begin
            state         <= FILL;
            cnt           <= '0;
            pending       <= 1'b0;
            io.dout_valid <= 1'b0;
            io.dout_re    <= '0;
            io.dout_im    <= '0;
            io.dout_diff  <= 1'b0;
            io.frame_done <= 1'b0;
        end else begin
            io.dout_valid <= 1'b0;
            io.frame_done <= 1'b0;
            case (state)
                FILL: begin
                    if (drain_start) begin
                        io.dout_valid <= 1'b1;
                        io.dout_diff  <= 1'b1;
                        io.dout_re    <= rd_w[0];
                        io.dout_im    <= rd_w[1];
                        if (DEPTH == 1) begin
                            pending <= 1'b0;
                        end else begin
                            state <= DRAIN;
                            cnt   <= CW'(1);
                        end
                    end else if (accept) begin
                        if (pending) begin
                            io.dout_valid <= 1'b1;
                            io.dout_diff  <= 1'b1;
                            io.dout_re    <= rd_w[0];
                            io.dout_im    <= rd_w[1];
                        end
                        if (cnt == '0) begin
                            scale_q <= scale_en;
                        end
                        if (last_k) begin
                            pending <= 1'b0;
                            state   <= BFLY;
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                BFLY: begin
                    if (accept) begin
                        io.dout_valid <= 1'b1;
                        io.dout_diff  <= 1'b0;
                        io.dout_re    <= sum_w[0];
                        io.dout_im    <= sum_w[1];
                        if (last_k) begin
                            pending       <= 1'b1;
                            io.frame_done <= 1'b1;
                            state         <= FILL;
                            cnt           <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    io.dout_valid <= 1'b1;
                    io.dout_diff  <= 1'b1;
                    io.dout_re    <= rd_w[0];
                    io.dout_im    <= rd_w[1];
                    if (last_k) begin
                        pending <= 1'b0;
                        state   <= FILL;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= FILL;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fft_r2_sdf_stage.sv
// Scoreboard bench for fft_r2_sdf_stage: a behavioural integer model queues the expected output
// of every cycle, and the following cycle compares it with what the stage produced.
module tb_fft_r2_sdf_stage;
    localparam int DATA_W = 10;
    localparam int LANES  = 16;
    localparam int DEPTH  = 8;
    localparam int OW     = DATA_W + 1;

    typedef struct packed {
        logic                     valid;
        logic                     diff;
        logic                     fd;
        logic                     zero;
        logic [LANES-1:0][OW-1:0] re;
        logic [LANES-1:0][OW-1:0] im;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic sync_clr = 1'b0;
    logic scale_en = 1'b0;
    logic drain = 1'b0;

    fft_r2_sdf_stage_if #(.DATA_W(DATA_W), .LANES(LANES)) io ();

    fft_r2_sdf_stage #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .sync_clr (sync_clr),
        .scale_en (scale_en),
        .drain    (drain),
        .io       (io)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   drv_re[LANES];
    int   drv_im[LANES];
    int   mbuf_re[DEPTH][LANES];
    int   mbuf_im[DEPTH][LANES];
    int   mcnt = 0;
    int   mdidx = 0;
    bit   mpend = 1'b0;
    bit   mdrain = 1'b0;
    bit   mscale = 1'b0;

    function automatic int scl(input int x, input bit s);
        return s ? ((x + 1) >>> 1) : x;
    endfunction

    function automatic exp_t stored_beat(input int idx);
        exp_t e;
        e = '0;
        e.valid = 1'b1;
        e.diff  = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            e.re[l] = OW'(mbuf_re[idx][l]);
            e.im[l] = OW'(mbuf_im[idx][l]);
        end
        return e;
    endfunction

    task automatic set_const(input int re, input int im);
        for (int l = 0; l < LANES; l++) begin
            drv_re[l] = re;
            drv_im[l] = im;
        end
    endtask

    task automatic set_rand();
        for (int l = 0; l < LANES; l++) begin
            drv_re[l] = int'($urandom_range(1023, 0)) - 512;
            drv_im[l] = int'($urandom_range(1023, 0)) - 512;
        end
    endtask

    // One clock cycle: drive inputs, check the previous cycle's output, then queue this cycle's.
    task automatic step(input bit v, input bit dr, input bit clr, input bit sc);
        exp_t e;
        exp_t p;
        bit   exp_ready;
        int   kk;
        int   av;
        int   bv;
        @(posedge clk);
        #1;
        io.din_valid = v;
        drain        = dr;
        sync_clr     = clr;
        scale_en     = sc;
        for (int l = 0; l < LANES; l++) begin
            io.din_re[l] = drv_re[l][DATA_W-1:0];
            io.din_im[l] = drv_im[l][DATA_W-1:0];
        end
        @(negedge clk);
        if (q.size() > 0) begin
            p = q.pop_front();
            checks++;
            if (io.dout_valid !== p.valid) begin
                errors++;
                $display("[TB] FAIL dout_valid at %0t: got %b want %b", $time, io.dout_valid, p.valid);
            end
            checks++;
            if (io.frame_done !== p.fd) begin
                errors++;
                $display("[TB] FAIL frame_done at %0t: got %b want %b", $time, io.frame_done, p.fd);
            end
            if (p.valid || p.zero) begin
                checks++;
                if (io.dout_re !== p.re || io.dout_im !== p.im || io.dout_diff !== p.diff) begin
                    errors++;
                    $display("[TB] FAIL dout_beat at %0t: got re=%h im=%h diff=%b want re=%h im=%h diff=%b",
                             $time, io.dout_re, io.dout_im, io.dout_diff, p.re, p.im, p.diff);
                end
            end
        end

        exp_ready = !mdrain && !(mcnt == 0 && mpend && dr);
        checks++;
        if (io.din_ready !== exp_ready) begin
            errors++;
            $display("[TB] FAIL din_ready at %0t: got %b want %b", $time, io.din_ready, exp_ready);
        end

        e = '0;
        if (clr) begin
            e.zero = 1'b1;
            mcnt   = 0;
            mpend  = 1'b0;
            mdrain = 1'b0;
        end else if (mdrain) begin
            e = stored_beat(mdidx);
            mdidx++;
            if (mdidx == DEPTH) begin
                mdrain = 1'b0;
                mpend  = 1'b0;
            end
        end else if (!exp_ready) begin
            e = stored_beat(0);
            if (DEPTH == 1) mpend = 1'b0;
            else begin
                mdrain = 1'b1;
                mdidx  = 1;
            end
        end else if (v) begin
            if (mcnt < DEPTH) begin
                if (mcnt == 0) mscale = sc;
                if (mpend) e = stored_beat(mcnt);
                for (int l = 0; l < LANES; l++) begin
                    mbuf_re[mcnt][l] = drv_re[l];
                    mbuf_im[mcnt][l] = drv_im[l];
                end
                if (mcnt == DEPTH - 1) mpend = 1'b0;
            end else begin
                kk = mcnt - DEPTH;
                e.valid = 1'b1;
                for (int l = 0; l < LANES; l++) begin
                    av = mbuf_re[kk][l];
                    bv = drv_re[l];
                    e.re[l] = OW'(scl(av + bv, mscale));
                    mbuf_re[kk][l] = scl(av - bv, mscale);
                    av = mbuf_im[kk][l];
                    bv = drv_im[l];
                    e.im[l] = OW'(scl(av + bv, mscale));
                    mbuf_im[kk][l] = scl(av - bv, mscale);
                end
                if (kk == DEPTH - 1) begin
                    mpend = 1'b1;
                    e.fd  = 1'b1;
                end
            end
            mcnt = (mcnt + 1) % (2 * DEPTH);
        end
        q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        @(posedge clk);
        #1;
        rstn         = 1'b0;
        io.din_valid = 1'b0;
        drain        = 1'b0;
        sync_clr     = 1'b0;
        @(negedge clk);
        checks++;
        if (io.dout_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_dout_valid: got %b want 0", io.dout_valid);
        end
        checks++;
        if (io.frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_frame_done: got %b want 0", io.frame_done);
        end
        checks++;
        if (io.dout_re !== '0 || io.dout_im !== '0 || io.dout_diff !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_dout: got re=%h im=%h diff=%b want all 0", io.dout_re, io.dout_im, io.dout_diff);
        end
        checks++;
        if (io.din_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_din_ready: got %b want 1", io.din_ready);
        end
        q.delete();
        mcnt   = 0;
        mpend  = 1'b0;
        mdrain = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        e = '0;
        q.push_back(e);
    endtask

    // Ramp fill against a constant second half; the first beat also carries an ignorable drain.
    task automatic test_basic();
        for (int k = 0; k < 2 * DEPTH; k++) begin
            set_const((k < DEPTH) ? k + 1 : 10, 0);
            step(1'b1, k == 0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_extremes();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 2 * DEPTH; k++) begin
                set_rand();
                if (k < DEPTH) begin
                    drv_re[0] = -512; drv_re[1] = 511;  drv_re[2] = 511;
                    drv_im[0] = 511;  drv_im[1] = -512;
                end else begin
                    drv_re[0] = -512; drv_re[1] = -512; drv_re[2] = 511;
                    drv_im[0] = 511;  drv_im[1] = 511;
                end
                step(1'b1, 1'b0, 1'b0, f[0]);
            end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 2 * DEPTH; k++) begin
            if (k == 5) begin
                for (int s = 0; s < 3; s++) step(1'b0, 1'b0, 1'b0, s[0]);
            end
            set_rand();
            step(1'b1, 1'b0, 1'b0, k != 0);
        end
    endtask

    task automatic test_drain();
        set_rand();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < DEPTH; k++) begin
            set_rand();
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 2 * DEPTH; k++) begin
            set_rand();
            step(1'b1, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_clear();
        for (int k = 0; k < 11; k++) begin
            set_rand();
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        set_rand();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2 * DEPTH + 2; k++) begin
            set_rand();
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 2 * DEPTH; k++) begin
            set_rand();
            step(1'b1, 1'b0, 1'b0, 1'b1);
        end
        for (int k = 0; k < 11; k++) begin
            set_rand();
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        test_reset();
        for (int k = 0; k < 2 * DEPTH; k++) begin
            set_rand();
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        io.din_valid = 1'b0;
        io.din_re    = '0;
        io.din_im    = '0;
        set_const(0, 0);
        test_reset();
        test_basic();
        test_extremes();
        test_stall();
        test_drain();
        test_clear();
        set_const(0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
